pilha_dados: RTL

Hardware operand stack for the 16-bit stack processor, directly downstream of the control unit. It consumes the control unit's stack strobes and write data, and the ALU result. It holds operands in a register array and returns popped values to the temporary registers that feed the ALU. It also exposes top-of-stack and fullness status back to control.

---
 rtl/pilha_dados_if.sv | 28 ++
 rtl/pilha_dados.sv | 84 ++++++++
 2 files changed

// File: rtl/pilha_dados_if.sv
// Interface bundle between the control unit and the operand stack.
// The master modport is the control side; the slave modport is the stack.
interface pilha_dados_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
);
    logic             pilha_en;
    logic             pilha_wren;
    logic             controle_pilha;
    logic [WIDTH-1:0] data_pilha;
    logic [WIDTH-1:0] ula_res;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] topo;
    logic [AW:0]      count;
    logic             vazia;
    logic             cheia;
    logic             erro;

    modport master (
        output pilha_en, pilha_wren, controle_pilha, data_pilha, ula_res,
        input  data_out, topo, count, vazia, cheia, erro
    );

    modport slave (
        input  pilha_en, pilha_wren, controle_pilha, data_pilha, ula_res,
        output data_out, topo, count, vazia, cheia, erro
    );
endinterface

// File: rtl/pilha_dados.sv
// Operand stack for the 16-bit stack processor: push/pop register array with top-of-stack status.
// Define PILHA_CHECK_EN to reject overflow/underflow and raise a sticky erro; otherwise the stack wraps.
module pilha_dados #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    pilha_dados_if.slave     bus
);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    sp_p0;
    logic [AW-1:0]    sp_dec;
    logic [AW:0]      cnt_p0;
    logic [WIDTH-1:0] pop_data_p1;
    logic [WIDTH-1:0] push_src;
    logic             is_full;
    logic             is_empty;
    logic             push_req;
    logic             pop_req;
    logic             do_push;
    logic             do_pop;

    assign sp_dec   = sp_p0 - AW'(1);
    assign is_full  = (cnt_p0 == CNT_FULL);
    assign is_empty = (cnt_p0 == '0);
    assign push_req = bus.pilha_en & bus.pilha_wren;
    assign pop_req  = bus.pilha_en & ~bus.pilha_wren;
    assign push_src = bus.controle_pilha ? bus.ula_res : bus.data_pilha;

`ifdef PILHA_CHECK_EN
    assign do_push = push_req & ~is_full;
    assign do_pop  = pop_req & ~is_empty;
`else
    assign do_push = push_req;
    assign do_pop  = pop_req;
`endif

    // Stage p0 -> p1: pointer, occupancy and popped word; count saturates so wrap mode keeps 0..DEPTH
    always_ff @(posedge clock) begin
        if (!reset) begin
            sp_p0       <= '0;
            cnt_p0      <= '0;
            pop_data_p1 <= '0;
        end else if (do_push) begin
            sp_p0 <= sp_p0 + AW'(1);
            if (!is_full) cnt_p0 <= cnt_p0 + CNT_ONE;
        end else if (do_pop) begin
            sp_p0       <= sp_dec;
            pop_data_p1 <= mem[sp_dec];
            if (!is_empty) cnt_p0 <= cnt_p0 - CNT_ONE;
        end
    end

    // Storage is never cleared; a push coinciding with reset is dropped.
    always_ff @(posedge clock) begin
        if (reset && do_push) mem[sp_p0] <= push_src;
    end

`ifdef PILHA_CHECK_EN
    logic erro_p1;

    always_ff @(posedge clock) begin
        if (!reset)
            erro_p1 <= 1'b0;
        else if ((push_req & is_full) | (pop_req & is_empty))
            erro_p1 <= 1'b1;
    end

    assign bus.erro = erro_p1;
`else
    assign bus.erro = 1'b0;
`endif

    assign bus.data_out = pop_data_p1;
    assign bus.topo     = is_empty ? '0 : mem[sp_dec];
    assign bus.count    = cnt_p0;
    assign bus.vazia    = is_empty;
    assign bus.cheia    = is_full;
endmodule
